// File: rtl/rvv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rvv_pkg
//  Description : Shared types, opcode constants and decode helpers for the
//                vector-accelerator predecode queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package rvv_pkg;

    // Operand / class information forwarded with every dispatched vector op
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
        logic fs1;
        logic fs2;
        logic fd;
        logic vfp;
        logic load;
        logic store;
        logic amo;
    } accel_info_t;

    // Major opcodes
    localparam logic [6:0] c_OPC_VECTOR   = 7'b1010111;
    localparam logic [6:0] c_OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] c_OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] c_OPC_AMO      = 7'b0101111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    // OP-V func3 categories
    localparam logic [2:0] c_OPIVV = 3'b000;
    localparam logic [2:0] c_OPFVV = 3'b001;
    localparam logic [2:0] c_OPMVV = 3'b010;
    localparam logic [2:0] c_OPIVI = 3'b011;
    localparam logic [2:0] c_OPIVX = 3'b100;
    localparam logic [2:0] c_OPFVF = 3'b101;
    localparam logic [2:0] c_OPMVX = 3'b110;
    localparam logic [2:0] c_OPCFG = 3'b111;

    // func6 of the scalar-move unary group (vmv.x.s / vfmv.f.s)
    localparam logic [5:0] c_FUNC6_UNARY0 = 6'b010000;
    // func7 of vsetvl (register-sourced vtype)
    localparam logic [6:0] c_FUNC7_VSETVL = 7'b1000000;
    // Strided addressing mode, which reads a second scalar register
    localparam logic [1:0] c_MOP_STRIDED  = 2'b10;

    // Vector CSR address map
    function automatic logic is_vector_csr(input logic [11:0] csr);
        case (csr)
            12'h008, 12'h009, 12'h00A, 12'h00F,
            12'hC20, 12'hC21, 12'hC22: is_vector_csr = 1'b1;
            default:                   is_vector_csr = 1'b0;
        endcase
    endfunction

    // {mew,width} codes that belong to vector loads/stores rather than scalar FP
    function automatic logic is_vector_mem_width(input logic [3:0] mew_width);
        case (mew_width)
            4'b0000, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1101, 4'b1110, 4'b1111: is_vector_mem_width = 1'b1;
            default:                            is_vector_mem_width = 1'b0;
        endcase
    endfunction

    // Anything that touches memory counts against the in-flight budget
    function automatic logic is_mem_op(input accel_info_t info);
        is_mem_op = info.load | info.store | info.amo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_slot_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : accel_slot_decoder
//  Description : Purely combinational classifier for one instruction slot:
//                flags vector-unit instructions and the scalar operands /
//                memory class they carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_slot_decoder
    import rvv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_accel,
    output accel_info_t o_info
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_func3;
    logic [5:0]  w_func6;
    logic [6:0]  w_func7;
    logic [1:0]  w_func2;
    logic        w_mew;
    logic [1:0]  w_mop;
    logic [11:0] w_csr;
    logic        w_unused_bits;

    assign w_opcode = i_instr[6:0];
    assign w_func3  = i_instr[14:12];
    assign w_func6  = i_instr[31:26];
    assign w_func7  = i_instr[31:25];
    assign w_func2  = i_instr[31:30];
    assign w_mew    = i_instr[28];
    assign w_mop    = i_instr[27:26];
    assign w_csr    = i_instr[31:20];

    // Register specifier fields carry no classification information
    assign w_unused_bits = ^{i_instr[19:15], i_instr[11:7]};

    // Classify the slot and collect its operand requirements
    always_comb begin
        o_is_accel = 1'b0;
        o_info     = '0;
        case (w_opcode)
            c_OPC_VECTOR: begin
                o_is_accel = 1'b1;
                case (w_func3)
                    c_OPFVV: begin
                        o_info.vfp = 1'b1;
                        o_info.fd  = (w_func6 == c_FUNC6_UNARY0);
                    end
                    c_OPMVV: o_info.rd = (w_func6 == c_FUNC6_UNARY0);
                    c_OPIVX,
                    c_OPMVX: o_info.rs1 = 1'b1;
                    c_OPFVF: begin
                        o_info.fs1 = 1'b1;
                        o_info.vfp = 1'b1;
                    end
                    c_OPCFG: begin
                        o_info.rd  = 1'b1;
                        // vsetivli encodes the AVL as an immediate
                        o_info.rs1 = (w_func2 != 2'b11);
                        o_info.rs2 = (w_func7 == c_FUNC7_VSETVL);
                    end
                    default: ;
                endcase
            end
            c_OPC_LOAD_FP,
            c_OPC_STORE_FP: begin
                if (is_vector_mem_width({w_mew, w_func3})) begin
                    o_is_accel   = 1'b1;
                    o_info.rs1   = 1'b1;
                    o_info.rs2   = (w_mop == c_MOP_STRIDED);
                    o_info.load  = (w_opcode == c_OPC_LOAD_FP);
                    o_info.store = (w_opcode == c_OPC_STORE_FP);
                end
            end
            c_OPC_AMO: begin
                case (w_func3)
                    3'b000, 3'b101, 3'b110, 3'b111: begin
                        o_is_accel = 1'b1;
                        o_info.rs1 = 1'b1;
                        o_info.amo = 1'b1;
                    end
                    default: ;
                endcase
            end
            c_OPC_SYSTEM: begin
                // func3 000 is ECALL/EBREAK/xRET, 100 is reserved: not CSR ops
                if ((w_func3 != 3'b000) && (w_func3 != 3'b100) && is_vector_csr(w_csr)) begin
                    o_is_accel = 1'b1;
                    o_info.rs1 = 1'b1;
                    o_info.rs2 = 1'b1;
                    o_info.rd  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/accel_predecode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : accel_predecode_queue
//  Description : Decodes NrPorts instruction slots per cycle, queues vector
//                instructions in a flop-based circular buffer and dispatches
//                them one at a time, throttling memory ops against an
//                in-flight limit.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_predecode_queue
    import rvv_pkg::*;
#(
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned Depth     = 4,
    parameter int unsigned MaxMemOut = 7
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NrPorts-1:0][31:0]           instr_i,
    input  logic [NrPorts-1:0]                 instr_valid_i,
    output logic                               instr_ready_o,
    output logic [NrPorts-1:0]                 is_accel_o,
    input  logic                               flush_i,
    output logic                               acc_valid_o,
    input  logic                               acc_ready_i,
    output logic [31:0]                        acc_instr_o,
    output accel_info_t                        acc_info_o,
    input  logic                               mem_done_i,
    output logic [$clog2(MaxMemOut+1)-1:0]     mem_out_o,
    output logic                               queue_empty_o
);

    localparam int unsigned c_IDX_W = $clog2(Depth);
    localparam int unsigned c_CNT_W = c_IDX_W + 1;
    localparam int unsigned c_MEM_W = $clog2(MaxMemOut + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(Depth);
    localparam logic [c_CNT_W-1:0] c_NR_PORTS = c_CNT_W'(NrPorts);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_MEM_W-1:0] c_MAX_MEM  = c_MEM_W'(MaxMemOut);
    localparam logic [c_MEM_W-1:0] c_MEM_ONE  = c_MEM_W'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [c_CNT_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_rd_ptr;
    logic [c_MEM_W-1:0] r_mem_out;

    logic [31:0]        r_instr_q [Depth];
    accel_info_t        r_info_q  [Depth];

    logic [NrPorts-1:0] w_is_accel;
    accel_info_t        w_slot_info [NrPorts];
    logic [NrPorts-1:0] w_push;
    logic [c_CNT_W-1:0] w_push_ofs  [NrPorts];
    logic [c_IDX_W-1:0] w_wr_addr   [NrPorts];
    logic [c_CNT_W-1:0] w_push_cnt;

    logic [c_CNT_W-1:0] w_used;
    logic [c_CNT_W-1:0] w_free;
    logic [c_IDX_W-1:0] w_head_idx;
    logic               w_empty;
    logic               w_head_mem;
    logic               w_accept;
    logic               w_pop;
    logic               w_mem_inc;
    logic               w_mem_dec;

    generate
        for (genvar gi = 0; gi < NrPorts; gi++) begin : g_slot
            accel_slot_decoder u_dec (
                .i_instr    (instr_i[gi]),
                .o_is_accel (w_is_accel[gi]),
                .o_info     (w_slot_info[gi])
            );
        end
    endgenerate

    assign is_accel_o = w_is_accel;

    // Occupancy is taken before any pop this cycle, so a pop never frees
    // room for a same-cycle enqueue
    assign w_used        = r_wr_ptr - r_rd_ptr;
    assign w_free        = c_DEPTH - w_used;
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign instr_ready_o = (w_free >= c_NR_PORTS);
    assign queue_empty_o = w_empty;

    // Head is read straight from the storage flops; a freshly written entry
    // therefore becomes visible one cycle after its enqueue
    assign w_head_idx  = r_rd_ptr[c_IDX_W-1:0];
    assign acc_instr_o = r_instr_q[w_head_idx];
    assign acc_info_o  = r_info_q[w_head_idx];
    assign w_head_mem  = is_mem_op(r_info_q[w_head_idx]);
    assign acc_valid_o = !w_empty && !(w_head_mem && (r_mem_out == c_MAX_MEM));
    assign mem_out_o   = r_mem_out;

    // A flush swallows both the incoming slots and any handshake this cycle
    assign w_accept  = instr_ready_o && !flush_i;
    assign w_pop     = acc_valid_o && acc_ready_i && !flush_i;
    assign w_mem_inc = w_pop && w_head_mem;
    assign w_mem_dec = mem_done_i && (r_mem_out != '0);

    // Pack the accepted vector slots densely in program order
    always_comb begin
        w_push_cnt = '0;
        for (int i = 0; i < NrPorts; i++) begin
            w_push[i]     = w_accept && instr_valid_i[i] && w_is_accel[i];
            w_push_ofs[i] = w_push_cnt;
            w_wr_addr[i]  = c_IDX_W'(r_wr_ptr + w_push_cnt);
            if (w_push[i]) begin
                w_push_cnt = w_push_cnt + c_CNT_ONE;
            end
        end
    end

    // Write the packed slots into the flop storage
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrPorts; i++) begin
            if (w_push[i]) begin
                r_instr_q[w_wr_addr[i]] <= instr_i[i];
                r_info_q[w_wr_addr[i]]  <= w_slot_info[i];
            end
        end
    end

    // Advance the pointers and track outstanding memory operations
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_out <= '0;
        end else begin
            if (flush_i) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr + w_push_cnt;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_CNT_ONE;
                end
            end
            if (w_mem_inc && !w_mem_dec) begin
                r_mem_out <= r_mem_out + c_MEM_ONE;
            end else if (w_mem_dec && !w_mem_inc) begin
                r_mem_out <= r_mem_out - c_MEM_ONE;
            end
        end
    end

endmodule
`default_nettype wire
